// File: rtl/pixel_remap_if.sv
// Source-read / destination-write bus of the pixel remapper.
// master drives the strobes and addresses, slave returns read data and ready.
interface pixel_remap_if #(
    parameter int PIX_W  = 12,
    parameter int SRC_AW = 19,
    parameter int DST_AW = 17
);
    logic              src_re;
    logic [SRC_AW-1:0] src_addr;
    logic [PIX_W-1:0]  src_rdata;
    logic              dst_we;
    logic [DST_AW-1:0] dst_addr;
    logic [PIX_W-1:0]  dst_data;
    logic              dst_ready;

    modport master (
        output src_re, src_addr, dst_we, dst_addr, dst_data,
        input  src_rdata, dst_ready
    );

    modport slave (
        input  src_re, src_addr, dst_we, dst_addr, dst_data,
        output src_rdata, dst_ready
    );
endinterface

// File: rtl/pixel_remap.sv
// Nearest-neighbour power-of-two downscaling copy from source to destination buffer.
// Define PIXEL_REMAP_MIRROR_EN to add the mirror_x horizontal-flip input.
module pixel_remap #(
    parameter int DST_W  = 320,
    parameter int DST_H  = 240,
    parameter int SHIFT  = 1,
    parameter int PIX_W  = 12,
    parameter int SRC_AW = 19,
    parameter int DST_AW = 17,
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic cont,
`ifdef PIXEL_REMAP_MIRROR_EN
    input  logic mirror_x,
`endif
    output logic busy,
    output logic done,
    pixel_remap_if.master bus
);
    localparam int XW  = (DST_W > 1) ? $clog2(DST_W) : 1;
    localparam int YW  = (DST_H > 1) ? $clog2(DST_H) : 1;
    localparam int WCW = $clog2(RD_LAT + 1);

    localparam logic [XW-1:0]     X_LAST   = XW'(DST_W - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(DST_H - 1);
    localparam logic [WCW-1:0]    W_LAST   = WCW'(RD_LAT - 1);
    localparam logic [SRC_AW-1:0] X_STEP   = SRC_AW'(1 << SHIFT);
    localparam logic [SRC_AW-1:0] ROW_STEP = SRC_AW'((DST_W << SHIFT) << SHIFT);
    localparam logic [SRC_AW-1:0] X_END    = SRC_AW'((DST_W - 1) << SHIFT);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;

    state_t            state, state_n;
    logic [XW-1:0]     dst_x;
    logic [YW-1:0]     dst_y;
    logic [WCW-1:0]    wcnt;
    logic [SRC_AW-1:0] row_base;
    logic [SRC_AW-1:0] row_nxt;
    logic [SRC_AW-1:0] frm_x0;
    logic [SRC_AW-1:0] row_x0;
    logic [SRC_AW-1:0] col_nxt;
    logic              cont_q;
    logic              clr, adv, cap, fin;
    logic              is_last;

    assign is_last = (dst_x == X_LAST) && (dst_y == Y_LAST);
    assign row_nxt = row_base + ROW_STEP;

`ifdef PIXEL_REMAP_MIRROR_EN
    logic mir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   mir_q <= 1'b0;
        else if (clr) mir_q <= mirror_x;
    end

    // Mirrored rows start at the rightmost sample and walk leftwards
    assign frm_x0  = mirror_x ? X_END : '0;
    assign row_x0  = mir_q ? X_END : '0;
    assign col_nxt = mir_q ? bus.src_addr - X_STEP : bus.src_addr + X_STEP;
`else
    assign frm_x0  = '0;
    assign row_x0  = '0;
    assign col_nxt = bus.src_addr + X_STEP;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        adv     = 1'b0;
        cap     = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_n = RD;
                end
            end
            RD: state_n = WAIT;
            WAIT: begin
                if (wcnt == W_LAST) begin
                    cap     = 1'b1;
                    state_n = WR;
                end
            end
            WR: begin
                if (bus.dst_ready) begin
                    if (is_last) begin
                        fin     = 1'b1;
                        state_n = DONE;
                    end else begin
                        adv     = 1'b1;
                        state_n = RD;
                    end
                end
            end
            DONE: begin
                if (cont_q) begin
                    clr     = 1'b1;
                    state_n = RD;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output is a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.src_re   <= 1'b0;
            bus.dst_we   <= 1'b0;
            bus.src_addr <= '0;
            bus.dst_addr <= '0;
            bus.dst_data <= '0;
            dst_x        <= '0;
            dst_y        <= '0;
            row_base     <= '0;
            wcnt         <= '0;
            cont_q       <= 1'b0;
        end else begin
            busy       <= (state_n != IDLE);
            done       <= (state_n == DONE);
            bus.src_re <= (state_n == RD);
            bus.dst_we <= (state_n == WR);
            wcnt       <= (state == WAIT) ? wcnt + WCW'(1) : '0;
            if (cap) bus.dst_data <= bus.src_rdata;
            if (fin) cont_q <= cont;
            if (clr) begin
                dst_x        <= '0;
                dst_y        <= '0;
                row_base     <= '0;
                bus.dst_addr <= '0;
                bus.src_addr <= frm_x0;
            end else if (adv) begin
                bus.dst_addr <= bus.dst_addr + DST_AW'(1);
                if (dst_x == X_LAST) begin
                    dst_x        <= '0;
                    dst_y        <= dst_y + YW'(1);
                    row_base     <= row_nxt;
                    bus.src_addr <= row_nxt + row_x0;
                end else begin
                    dst_x        <= dst_x + XW'(1);
                    bus.src_addr <= col_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_pixel_remap.sv
// Scoreboard bench for pixel_remap on a 4x3 destination, 2x downscale, 2-cycle reads.
// Directed frames cover timing/backpressure/continuous/reset; random frames use random data and ready.
module tb_pixel_remap;
    localparam int DW  = 4;
    localparam int DH  = 3;
    localparam int SH  = 1;
    localparam int RL  = 2;
    localparam int PW  = 12;
    localparam int SAW = 19;
    localparam int DAW = 17;
    localparam int NSRC = (DW << SH) * (DH << SH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cont  = 1'b0;
`ifdef PIXEL_REMAP_MIRROR_EN
    logic mirror_x = 1'b0;
`endif
    logic busy;
    logic done;

    pixel_remap_if #(.PIX_W(PW), .SRC_AW(SAW), .DST_AW(DAW)) bus ();

    pixel_remap #(
        .DST_W(DW), .DST_H(DH), .SHIFT(SH), .PIX_W(PW),
        .SRC_AW(SAW), .DST_AW(DAW), .RD_LAT(RL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .cont(cont),
`ifdef PIXEL_REMAP_MIRROR_EN
        .mirror_x(mirror_x),
`endif
        .busy(busy),
        .done(done),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Source memory with RL-cycle read latency; garbage when no read is due
    logic [PW-1:0]  mem [64];
    logic [SAW-1:0] pa  [RL];
    logic           pv  [RL];

    always @(posedge clk) begin
        pa[0] <= bus.src_addr;
        pv[0] <= bus.src_re;
        for (int i = 1; i < RL; i++) begin
            pa[i] <= pa[i-1];
            pv[i] <= pv[i-1];
        end
    end

    assign bus.src_rdata = !pv[RL-1] ? 12'hBAD :
                           (pa[RL-1] < NSRC) ? mem[pa[RL-1][5:0]] : 12'hEEE;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  n_chk = 0;
    int  n_fail = 0;
    int  done_cnt = 0;
    int  cyc = 0;
    int  last_acc_cyc = -100;
    int  last_acc_addr = -1;
    bit  spacing = 1'b1;
    bit  prev_stall = 1'b0;
    int  h_addr;
    int  h_data;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_we", int'(bus.dst_we), 1);
                chk("stall_addr", int'(bus.dst_addr), h_addr);
                chk("stall_data", int'(bus.dst_data), h_data);
            end
            if (bus.dst_we) chk("re_in_wr", int'(bus.src_re), 0);
            prev_stall = bus.dst_we && !bus.dst_ready;
            h_addr = int'(bus.dst_addr);
            h_data = int'(bus.dst_data);
            if (bus.dst_we && bus.dst_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_wr", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_addr", int'(bus.dst_addr), mon_e.addr);
                    chk("wr_data", int'(bus.dst_data), mon_e.data);
                    if (spacing && mon_e.addr != 0)
                        chk("wr_spacing", cyc - last_acc_cyc, RL + 2);
                    last_acc_cyc  = cyc;
                    last_acc_addr = mon_e.addr;
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_timing", cyc - last_acc_cyc, 1);
                chk("done_last", last_acc_addr, DW * DH - 1);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: destination pixel (x,y) copies source pixel (sx<<SH, y<<SH)
    task automatic push_frame(bit m);
        for (int y = 0; y < DH; y++) begin
            for (int x = 0; x < DW; x++) begin
                int sx;
                int sa;
                wr_t e;
                sx = (m ? (DW - 1 - x) : x) << SH;
                sa = (y << SH) * (DW << SH) + sx;
                e.addr = y * DW + x;
                e.data = int'(mem[sa]);
                sb.push_back(e);
            end
        end
    endtask

    task automatic start_frame(int a0);
        start = 1'b1;
        tick();
        chk("start_re", int'(bus.src_re), 1);
        chk("start_addr", int'(bus.src_addr), a0);
        chk("start_busy", int'(busy), 1);
        start = 1'b0;
        repeat (RL) tick();
        chk("we_early", int'(bus.dst_we), 0);
        tick();
        chk("we_latency", int'(bus.dst_we), 1);
    endtask

    task automatic wait_done(bit rnd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            if (rnd) bus.dst_ready = ($urandom_range(0, 3) != 0);
            tick();
            seen = done;
        end
        chk("done_seen", int'(seen), 1);
        bus.dst_ready = 1'b1;
    endtask

    task automatic wait_wr(int a);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            hit = bus.dst_we && (int'(bus.dst_addr) == a);
        end
        chk("wr_reached", int'(hit), 1);
    endtask

    task automatic wait_src(int a);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            hit = bus.src_re && (int'(bus.src_addr) == a);
        end
        chk("rd_reached", int'(hit), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit m;
        for (int i = 0; i < 64; i++) mem[i] = PW'(i);
        bus.dst_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_src_re", int'(bus.src_re), 0);
        chk("rst_dst_we", int'(bus.dst_we), 0);
        chk("rst_src_addr", int'(bus.src_addr), 0);
        chk("rst_dst_addr", int'(bus.dst_addr), 0);
        chk("rst_dst_data", int'(bus.dst_data), 0);
        rst_n = 1'b1;
        tick();

        // Single frame at full rate
        spacing = 1'b1;
        d0 = done_cnt;
        push_frame(1'b0);
        start_frame(0);
        wait_wr(5);
        chk("data_at_5", int'(bus.dst_data), 18);
        wait_wr(11);
        chk("data_at_11", int'(bus.dst_data), 38);
        wait_done(1'b0);
        tick();
        chk("single_idle", int'(busy), 0);
        chk("single_done_cnt", done_cnt - d0, 1);
        chk("single_sb_empty", sb.size(), 0);

        // Destination backpressure on pixel 2
        spacing = 1'b0;
        push_frame(1'b0);
        start_frame(0);
        wait_src(4);
        bus.dst_ready = 1'b0;
        for (int i = 0; i < 20 && !bus.dst_we; i++) tick();
        chk("bp_addr", int'(bus.dst_addr), 2);
        chk("bp_data", int'(bus.dst_data), 4);
        tick();
        tick();
        chk("bp_we_held", int'(bus.dst_we), 1);
        chk("bp_no_re", int'(bus.src_re), 0);
        bus.dst_ready = 1'b1;
        wait_done(1'b0);
        tick();
        chk("bp_idle", int'(busy), 0);
        chk("bp_sb_empty", sb.size(), 0);

        // Continuous mode, dropped during the second frame
        spacing = 1'b1;
        cont = 1'b1;
        push_frame(1'b0);
        push_frame(1'b0);
        start_frame(0);
        wait_done(1'b0);
        chk("cont_busy_done", int'(busy), 1);
        tick();
        chk("cont_re", int'(bus.src_re), 1);
        chk("cont_addr", int'(bus.src_addr), 0);
        cont = 1'b0;
        wait_done(1'b0);
        tick();
        chk("cont_end_idle", int'(busy), 0);
        repeat (5) tick();
        chk("cont_no_re", int'(bus.src_re), 0);
        chk("cont_still_idle", int'(busy), 0);
        chk("cont_sb_empty", sb.size(), 0);

        // Asynchronous reset in the middle of a frame
        push_frame(1'b0);
        start_frame(0);
        wait_wr(6);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("arst_src_re", int'(bus.src_re), 0);
        chk("arst_dst_we", int'(bus.dst_we), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_src_addr", int'(bus.src_addr), 0);
        chk("arst_dst_addr", int'(bus.dst_addr), 0);
        chk("arst_dst_data", int'(bus.dst_data), 0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_no_done", done_cnt - d0, 0);
        push_frame(1'b0);
        start_frame(0);
        chk("arst_restart_addr", int'(bus.dst_addr), 0);
        wait_done(1'b0);
        tick();
        chk("arst_done_cnt", done_cnt - d0, 1);
        chk("arst_sb_empty", sb.size(), 0);

        // start pulsed mid-frame must be ignored
        d0 = done_cnt;
        push_frame(1'b0);
        start_frame(0);
        wait_wr(3);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        wait_done(1'b0);
        tick();
        repeat (4) tick();
        chk("ign_done_cnt", done_cnt - d0, 1);
        chk("ign_idle", int'(busy), 0);
        chk("ign_sb_empty", sb.size(), 0);

`ifdef PIXEL_REMAP_MIRROR_EN
        // Mirrored frame; mirror_x dropped mid-frame must not matter
        mirror_x = 1'b1;
        push_frame(1'b1);
        start_frame(6);
        chk("mir_data_0", int'(bus.dst_data), 6);
        mirror_x = 1'b0;
        wait_wr(3);
        chk("mir_data_3", int'(bus.dst_data), 0);
        wait_wr(4);
        chk("mir_data_4", int'(bus.dst_data), 22);
        wait_done(1'b0);
        tick();
        chk("mir_sb_empty", sb.size(), 0);
`endif

        // Random source contents and random destination stalls
        spacing = 1'b0;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NSRC; i++) mem[i] = PW'($urandom_range(0, 4095));
            m = 1'b0;
`ifdef PIXEL_REMAP_MIRROR_EN
            m = 1'($urandom_range(0, 1));
            mirror_x = m;
`endif
            push_frame(m);
            start_frame(m ? ((DW - 1) << SH) : 0);
            wait_done(1'b1);
            tick();
            chk("rnd_sb_empty", sb.size(), 0);
            chk("rnd_idle", int'(busy), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
